// File: rtl/vga_window_timing.sv
// Parametrised VGA timing generator: registered active-area coordinates,
// run-time rectangle hit flags, and sync/blank re-aligned to late-arriving RGB.

module vga_win_hit #(
   parameter int CW = 10
) (
   input  logic [4*CW-1:0] rect_i,
   input  logic            en_i,
   input  logic            act_i,
   input  logic [CW-1:0]   x_i,
   input  logic [CW-1:0]   y_i,
   output logic            hit_o
);
   logic [CW-1:0] wx, wy, ww, wh;
   logic [CW:0]   x_end, y_end;

   assign {wx, wy, ww, wh} = rect_i;

   // One extra bit so a window hanging past 2^CW keeps its full span.
   assign x_end = {1'b0, wx} + {1'b0, ww};
   assign y_end = {1'b0, wy} + {1'b0, wh};

   assign hit_o = act_i && en_i &&
                  (x_i >= wx) && ({1'b0, x_i} < x_end) &&
                  (y_i >= wy) && ({1'b0, y_i} < y_end);
endmodule

module vga_window_timing #(
   parameter int H_DISP   = 640,
   parameter int H_FPORCH = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BPORCH = 48,
   parameter int V_DISP   = 480,
   parameter int V_FPORCH = 11,
   parameter int V_SYNC   = 2,
   parameter int V_BPORCH = 31,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int CW       = 10,
   parameter int N_WIN    = 8,
   parameter int RGB_LAT  = 2
) (
   input  logic                  VGA_CLK,
   input  logic                  RESET,
   input  logic [N_WIN*4*CW-1:0] WIN_RECT,
   input  logic [N_WIN-1:0]      WIN_ENABLE,
   input  logic [23:0]           RGB,
   output logic [CW-1:0]         X,
   output logic [CW-1:0]         Y,
   output logic                  COORD_VALID,
   output logic [N_WIN-1:0]      WIN_EN,
   output logic                  FRAME_START,
   output logic                  VGA_HS,
   output logic                  VGA_VS,
   output logic                  VGA_BLANK_N,
   output logic [7:0]            VGA_R,
   output logic [7:0]            VGA_G,
   output logic [7:0]            VGA_B
);
   localparam int H_OFF = H_FPORCH + H_SYNC + H_BPORCH;
   localparam int H_TOT = H_OFF + H_DISP;
   localparam int V_OFF = V_FPORCH + V_SYNC + V_BPORCH;
   localparam int V_TOT = V_OFF + V_DISP;

   localparam logic [CW-1:0] H_LAST  = CW'(H_TOT - 1);
   localparam logic [CW-1:0] V_LAST  = CW'(V_TOT - 1);
   localparam logic [CW-1:0] H_OFF_C = CW'(H_OFF);
   localparam logic [CW-1:0] V_OFF_C = CW'(V_OFF);
   localparam logic [CW-1:0] HS_BEG  = CW'(H_FPORCH);
   localparam logic [CW-1:0] HS_END  = CW'(H_FPORCH + H_SYNC);
   localparam logic [CW-1:0] VS_BEG  = CW'(V_FPORCH);
   localparam logic [CW-1:0] VS_END  = CW'(V_FPORCH + V_SYNC);

   typedef struct packed {
      logic hs;
      logic vs;
      logic act;
   } sync_t;

   // Stage 0: raster counters
   logic [CW-1:0] hc_q, hc_d, vc_q, vc_d;

   always_comb begin
      hc_d = hc_q + CW'(1);
      vc_d = vc_q;
      if (hc_q == H_LAST) begin
         hc_d = '0;
         vc_d = (vc_q == V_LAST) ? '0 : vc_q + CW'(1);
      end
   end

   always_ff @(posedge VGA_CLK or posedge RESET) begin
      if (RESET) begin
         hc_q <= '0;
         vc_q <= '0;
      end else begin
         hc_q <= hc_d;
         vc_q <= vc_d;
      end
   end

   sync_t         raw;
   logic [CW-1:0] x_raw, y_raw;
   logic          frame_top;

   always_comb begin
      raw.hs    = (hc_q >= HS_BEG) && (hc_q < HS_END);
      raw.vs    = (vc_q >= VS_BEG) && (vc_q < VS_END);
      raw.act   = (hc_q >= H_OFF_C) && (vc_q >= V_OFF_C);
      x_raw     = raw.act ? hc_q - H_OFF_C : '0;
      y_raw     = raw.act ? vc_q - V_OFF_C : '0;
      frame_top = (hc_q == '0) && (vc_q == '0);
   end

   // Window shadows only move at the top of the frame so edits never tear.
   logic [N_WIN*4*CW-1:0] rect_s_q;
   logic [N_WIN-1:0]      en_s_q;

   always_ff @(posedge VGA_CLK or posedge RESET) begin
      if (RESET) begin
         rect_s_q <= '0;
         en_s_q   <= '0;
      end else if (frame_top) begin
         rect_s_q <= WIN_RECT;
         en_s_q   <= WIN_ENABLE;
      end
   end

   logic [N_WIN-1:0] hit_d;

   for (genvar i = 0; i < N_WIN; i++) begin : g_win
      vga_win_hit #(.CW(CW)) u_hit (
         .rect_i (rect_s_q[i*4*CW +: 4*CW]),
         .en_i   (en_s_q[i]),
         .act_i  (raw.act),
         .x_i    (x_raw),
         .y_i    (y_raw),
         .hit_o  (hit_d[i])
      );
   end

   // Stage 1: coordinates and flags handed to the pixel source
   logic [CW-1:0]    x_q, y_q;
   logic             cv_q, fs_q;
   logic [N_WIN-1:0] win_q;

   always_ff @(posedge VGA_CLK or posedge RESET) begin
      if (RESET) begin
         x_q   <= '0;
         y_q   <= '0;
         cv_q  <= 1'b0;
         fs_q  <= 1'b0;
         win_q <= '0;
      end else begin
         x_q   <= x_raw;
         y_q   <= y_raw;
         cv_q  <= raw.act;
         fs_q  <= (hc_q == H_OFF_C) && (vc_q == V_OFF_C);
         win_q <= hit_d;
      end
   end

   // dly_q[0] is stage 1; dly_q[RGB_LAT] lines up with RGB arriving now.
   sync_t [RGB_LAT:0] dly_q;

   always_ff @(posedge VGA_CLK or posedge RESET) begin
      if (RESET) begin
         dly_q <= '0;
      end else begin
         dly_q[0] <= raw;
         for (int j = 1; j <= RGB_LAT; j++) dly_q[j] <= dly_q[j-1];
      end
   end

   logic        hs_q, vs_q, blank_q;
   logic [23:0] rgb_q;

   always_ff @(posedge VGA_CLK or posedge RESET) begin
      if (RESET) begin
         hs_q    <= ~HS_POL;
         vs_q    <= ~VS_POL;
         blank_q <= 1'b0;
         rgb_q   <= '0;
      end else begin
         hs_q    <= dly_q[RGB_LAT].hs ? HS_POL : ~HS_POL;
         vs_q    <= dly_q[RGB_LAT].vs ? VS_POL : ~VS_POL;
         blank_q <= dly_q[RGB_LAT].act;
         rgb_q   <= dly_q[RGB_LAT].act ? RGB : '0;
      end
   end

   assign X           = x_q;
   assign Y           = y_q;
   assign COORD_VALID = cv_q;
   assign WIN_EN      = win_q;
   assign FRAME_START = fs_q;
   assign VGA_HS      = hs_q;
   assign VGA_VS      = vs_q;
   assign VGA_BLANK_N = blank_q;
   assign VGA_R       = rgb_q[23:16];
   assign VGA_G       = rgb_q[15:8];
   assign VGA_B       = rgb_q[7:0];
endmodule

// File: tb/tb_vga_window_timing.sv
// Directed bench for vga_window_timing on a shrunken raster (24x13 totals)
// so several frames, a window-probe table and a mid-line reset fit in a short run.

module tb_vga_window_timing;
   localparam int H_DISP = 16, H_FP = 2, H_SY = 3, H_BP = 3;
   localparam int V_DISP = 8,  V_FP = 1, V_SY = 2, V_BP = 2;
   localparam bit HS_POL = 1'b1, VS_POL = 1'b0;
   localparam int CW = 5, N_WIN = 8, L = 2;
   localparam int H_OFF = H_FP + H_SY + H_BP;
   localparam int H_TOT = H_OFF + H_DISP;
   localparam int V_OFF = V_FP + V_SY + V_BP;
   localparam int V_TOT = V_OFF + V_DISP;
   localparam int FRAME = H_TOT * V_TOT;
   localparam int RW    = 4 * CW;

   typedef struct {
      int x;
      int y;
      int w;
      int h;
   } rect_t;

   typedef struct {
      rect_t r;
      int    px;
      int    py;
      bit    exp;
   } probe_t;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic [N_WIN*RW-1:0]   win_rect = '0;
   logic [N_WIN-1:0]      win_enable = '0;
   logic [23:0]           rgb = 24'hC3C3C3;
   logic [CW-1:0]         x_o, y_o;
   logic                  cv_o, fs_o, hs_o, vs_o, blank_o;
   logic [N_WIN-1:0]      win_o;
   logic [7:0]            r_o, g_o, b_o;

   vga_window_timing #(
      .H_DISP(H_DISP), .H_FPORCH(H_FP), .H_SYNC(H_SY), .H_BPORCH(H_BP),
      .V_DISP(V_DISP), .V_FPORCH(V_FP), .V_SYNC(V_SY), .V_BPORCH(V_BP),
      .HS_POL(HS_POL), .VS_POL(VS_POL), .CW(CW), .N_WIN(N_WIN), .RGB_LAT(L)
   ) dut (
      .VGA_CLK(clk), .RESET(rst), .WIN_RECT(win_rect), .WIN_ENABLE(win_enable),
      .RGB(rgb), .X(x_o), .Y(y_o), .COORD_VALID(cv_o), .WIN_EN(win_o),
      .FRAME_START(fs_o), .VGA_HS(hs_o), .VGA_VS(vs_o), .VGA_BLANK_N(blank_o),
      .VGA_R(r_o), .VGA_G(g_o), .VGA_B(b_o)
   );

   always #5 clk = ~clk;

   int     checks = 0;
   int     failures = 0;
   int     k = 0;
   bit     win_chk = 1'b0;
   rect_t  rect_a[N_WIN];
   rect_t  rect_b[N_WIN];
   logic [N_WIN-1:0] en_m;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s cycle=%0d got=0x%0h want=0x%0h", nm, k, act, exp);
      end
   endtask

   task automatic set_win(input int i, input rect_t r);
      win_rect[i*RW +: RW] = {CW'(r.x), CW'(r.y), CW'(r.w), CW'(r.h)};
   endtask

   function automatic bit is_act(input int t);
      int hc, vc;
      hc = t % H_TOT;
      vc = (t / H_TOT) % V_TOT;
      return (hc >= H_OFF) && (vc >= V_OFF);
   endfunction

   function automatic logic [N_WIN-1:0] exp_win(input int t);
      int hc, vc, xx, yy;
      rect_t r;
      logic [N_WIN-1:0] e;
      e  = '0;
      hc = t % H_TOT;
      vc = (t / H_TOT) % V_TOT;
      xx = hc - H_OFF;
      yy = vc - V_OFF;
      if (is_act(t)) begin
         for (int i = 0; i < N_WIN; i++) begin
            r = (t / FRAME == 0) ? rect_a[i] : rect_b[i];
            e[i] = en_m[i] && xx >= r.x && xx < r.x + r.w && yy >= r.y && yy < r.y + r.h;
         end
      end
      return e;
   endfunction

   task automatic check_cycle();
      int t1, t2, hc, vc;
      bit a, hs_s, vs_s;
      logic [23:0] prgb;
      t1 = k - 1;
      hc = t1 % H_TOT;
      vc = (t1 / H_TOT) % V_TOT;
      a  = is_act(t1);
      chk("coord_valid", int'(cv_o), int'(a));
      chk("x", int'(x_o), a ? hc - H_OFF : 0);
      chk("y", int'(y_o), a ? vc - V_OFF : 0);
      chk("frame_start", int'(fs_o), int'(hc == H_OFF && vc == V_OFF));
      if (win_chk) chk("win_en", int'(win_o), int'(exp_win(t1)));
      t2 = k - 2 - L;
      hs_s = 1'b0;
      vs_s = 1'b0;
      a    = 1'b0;
      prgb = '0;
      if (t2 >= 0) begin
         hc   = t2 % H_TOT;
         vc   = (t2 / H_TOT) % V_TOT;
         hs_s = hc >= H_FP && hc < H_FP + H_SY;
         vs_s = vc >= V_FP && vc < V_FP + V_SY;
         a    = is_act(t2);
         if (a) prgb = {8'(hc - H_OFF), 8'(vc - V_OFF), 8'hA5};
      end
      chk("vga_hs", int'(hs_o), int'(hs_s ? HS_POL : !HS_POL));
      chk("vga_vs", int'(vs_o), int'(vs_s ? VS_POL : !VS_POL));
      chk("blank_n", int'(blank_o), int'(a));
      chk("rgb", int'({r_o, g_o, b_o}), int'(prgb));
   endtask

   // Source model: pixel for the coordinates published L cycles ago.
   task automatic drive_rgb();
      int t, hc, vc;
      t = k - 1 - L;
      rgb = 24'hC3C3C3;
      if (t >= 0 && is_act(t)) begin
         hc  = t % H_TOT;
         vc  = (t / H_TOT) % V_TOT;
         rgb = {8'(hc - H_OFF), 8'(vc - V_OFF), 8'hA5};
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      k++;
      check_cycle();
      drive_rgb();
   endtask

   probe_t tbl[10];
   int     fs_cnt;
   int     n;
   int     tgt;

   initial begin
      rect_a[0] = '{3, 2, 5, 3};
      rect_a[1] = '{28, 0, 8, 10};
      rect_a[2] = '{0, 0, 0, 8};
      rect_a[3] = '{5, 3, 4, 4};
      rect_a[4] = '{0, 0, 31, 31};
      rect_a[5] = '{4, 1, 30, 31};
      rect_a[6] = '{15, 7, 1, 1};
      rect_a[7] = '{0, 0, 16, 0};
      rect_b    = rect_a;
      rect_b[0] = '{10, 4, 6, 4};
      en_m      = 8'hEF;

      tbl[0] = '{'{3, 2, 8, 4}, 3, 3, 1'b1};
      tbl[1] = '{'{3, 2, 8, 4}, 10, 3, 1'b1};
      tbl[2] = '{'{3, 2, 8, 4}, 2, 3, 1'b0};
      tbl[3] = '{'{3, 2, 8, 4}, 11, 3, 1'b0};
      tbl[4] = '{'{3, 2, 8, 4}, 5, 5, 1'b1};
      tbl[5] = '{'{3, 2, 8, 4}, 5, 6, 1'b0};
      tbl[6] = '{'{3, 2, 8, 4}, 5, 1, 1'b0};
      tbl[7] = '{'{0, 0, 0, 8}, 0, 0, 1'b0};
      tbl[8] = '{'{4, 1, 30, 31}, 15, 7, 1'b1};
      tbl[9] = '{'{28, 0, 8, 10}, 3, 0, 1'b0};

      for (int i = 0; i < N_WIN; i++) set_win(i, rect_a[i]);
      win_enable = en_m;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_hs", int'(hs_o), int'(!HS_POL));
      chk("rst_vs", int'(vs_o), int'(!VS_POL));
      chk("rst_blank", int'(blank_o), 0);
      chk("rst_rgb", int'({r_o, g_o, b_o}), 0);
      chk("rst_win", int'(win_o), 0);
      chk("rst_fs", int'(fs_o), 0);
      chk("rst_cv", int'(cv_o), 0);

      // Two frames with a mid-frame window edit
      @(negedge clk);
      rst = 1'b0;
      k = 0;
      win_chk = 1'b1;
      fs_cnt = 0;
      for (int c = 0; c < 2 * FRAME + 20; c++) begin
         step();
         if (fs_o) fs_cnt++;
         if (k == V_OFF * H_TOT + H_OFF + 1 + L) chk("blank_before_first", int'(blank_o), 0);
         if (k == V_OFF * H_TOT + H_OFF + 2 + L) chk("first_pixel", int'({blank_o, r_o, g_o, b_o}), 32'h010000A5);
         if (k == V_OFF * H_TOT + H_OFF + 17 + L) chk("last_pixel", int'({blank_o, r_o, g_o, b_o}), 32'h010F00A5);
         if (k == V_OFF * H_TOT + H_OFF + 18 + L) chk("after_line", int'({blank_o, r_o, g_o, b_o}), 0);
         if (k == 5 * H_TOT + 10) set_win(0, rect_b[0]);
      end
      chk("frame_start_count", fs_cnt, 2);
      win_chk = 1'b0;

      // Window-0 probe table: program, wait for frame capture, sample one pixel
      foreach (tbl[p]) begin
         set_win(0, tbl[p].r);
         n = 0;
         do begin step(); n++; end while (((k - 1) % FRAME) != 0 && n < 2 * FRAME);
         chk("probe_capture", (k - 1) % FRAME, 0);
         tgt = (tbl[p].py + V_OFF) * H_TOT + tbl[p].px + H_OFF;
         n = 0;
         do begin step(); n++; end while (((k - 1) % FRAME) != tgt && n < 2 * FRAME);
         chk("probe_pos", (k - 1) % FRAME, tgt);
         chk($sformatf("probe%0d_win0", p), int'(win_o[0]), int'(tbl[p].exp));
      end

      // Asynchronous reset in the middle of an active line
      tgt = (V_OFF + 2) * H_TOT + H_OFF + 5;
      n = 0;
      do begin step(); n++; end while (((k - 2 - L) % FRAME) != tgt && n < 2 * FRAME);
      chk("pre_reset_blank", int'(blank_o), 1);
      #3;
      rst = 1'b1;
      #1;
      chk("async_hs", int'(hs_o), int'(!HS_POL));
      chk("async_vs", int'(vs_o), int'(!VS_POL));
      chk("async_blank", int'(blank_o), 0);
      chk("async_rgb", int'({r_o, g_o, b_o}), 0);
      chk("async_win", int'(win_o), 0);
      chk("async_cv", int'(cv_o), 0);
      @(posedge clk);
      #1;
      chk("held_hs", int'(hs_o), int'(!HS_POL));
      @(negedge clk);
      rst = 1'b0;
      rgb = 24'hC3C3C3;
      k = 0;
      for (int c = 0; c < 3 * H_TOT; c++) begin
         step();
         if (k == H_FP + 1 + L) chk("hs_before_first", int'(hs_o), int'(!HS_POL));
         if (k == H_FP + 2 + L) chk("hs_first", int'(hs_o), int'(HS_POL));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
